// File: rtl/dds_core.sv
// Direct digital synthesiser: phase accumulator, phase-offset stage and waveform stage,
// with a one-entry shadow configuration that is applied phase-continuously at accumulator wrap.
module dds_core #(
  parameter int ACC_WIDTH   = 24,
  parameter int PHASE_WIDTH = 10,
  parameter int DATA_WIDTH  = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [ACC_WIDTH-1:0]   cfg_ftw_i,
  input  logic [PHASE_WIDTH-1:0] cfg_poff_i,
  input  logic [1:0]             cfg_mode_i,
  output logic [PHASE_WIDTH-1:0] phase_o,
  output logic [DATA_WIDTH-1:0]  data_out_o,
  output logic                   data_valid_o,
  output logic                   wrap_o,
  output logic                   cfg_state_o
);

  // Config handshake: a transfer happens on a rising edge where cfg_valid_i and
  // cfg_ready_o are both high; cfg_ready_o is high exactly when no config is pending.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  localparam int  QSIZE = 2 ** (PHASE_WIDTH - 2);
  localparam int  MAGW  = DATA_WIDTH - 1;
  localparam real PI    = 3.14159265358979323846;
  localparam real AMP_R = 2.0 ** (DATA_WIDTH - 1) - 1.0;
  localparam real NPH_R = 2.0 ** PHASE_WIDTH;
  localparam logic [MAGW-1:0]       AMP = {MAGW{1'b1}};
  localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {MAGW{1'b0}}};

  logic [0:0]             state_q, state_d;
  logic                   load_shadow, apply_shadow;

  logic [ACC_WIDTH-1:0]   ftw_q, ftw_d;
  logic [PHASE_WIDTH-1:0] poff_q, poff_d;
  logic [1:0]             mode_q, mode_d;
  logic [ACC_WIDTH-1:0]   sh_ftw_q, sh_ftw_d;
  logic [PHASE_WIDTH-1:0] sh_poff_q, sh_poff_d;
  logic [1:0]             sh_mode_q, sh_mode_d;

  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH:0]     acc_sum;
  logic                   acc_carry;
  logic                   wrap_q, wrap_d;

  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [1:0]             mode_s1_q, mode_s1_d;
  logic                   en_s1_q, en_s1_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;

  logic [MAGW-1:0]        qlut [QSIZE];
  logic [1:0]             quad;
  logic [PHASE_WIDTH-3:0] q_idx, q_mirror, q_sel;
  logic [MAGW-1:0]        sine_mag;
  logic [DATA_WIDTH-1:0]  sine_val, square_val, tri_val, saw_val, wave_val;
  logic [PHASE_WIDTH-2:0] tri_lvl;
  logic [PHASE_WIDTH-1:0] tri_dbl;

  assign acc_sum   = {1'b0, acc_q} + {1'b0, ftw_q};
  assign acc_carry = acc_sum[ACC_WIDTH];

  // Config FSM: a pending shadow is applied at once when idle, or on the wrap edge when running.
  always_comb begin
    state_d      = state_q;
    load_shadow  = 1'b0;
    apply_shadow = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid_i) begin
          load_shadow = 1'b1;
          state_d     = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (!enable_i || acc_carry) begin
          apply_shadow = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sh_ftw_d  = sh_ftw_q;
    sh_poff_d = sh_poff_q;
    sh_mode_d = sh_mode_q;
    ftw_d     = ftw_q;
    poff_d    = poff_q;
    mode_d    = mode_q;
    if (load_shadow) begin
      sh_ftw_d  = cfg_ftw_i;
      sh_poff_d = cfg_poff_i;
      sh_mode_d = cfg_mode_i;
    end
    if (apply_shadow) begin
      ftw_d  = sh_ftw_q;
      poff_d = sh_poff_q;
      mode_d = sh_mode_q;
    end
  end

  // Pipeline advances with the enable token so data_out_o keeps the last valid sample.
  always_comb begin
    acc_d     = acc_q;
    wrap_d    = 1'b0;
    phase_d   = phase_q;
    mode_s1_d = mode_s1_q;
    en_s1_d   = enable_i;
    valid_d   = en_s1_q;
    data_d    = data_q;
    if (enable_i) begin
      acc_d     = acc_sum[ACC_WIDTH-1:0];
      wrap_d    = acc_carry;
      phase_d   = acc_q[ACC_WIDTH-1 -: PHASE_WIDTH] + poff_q;
      mode_s1_d = mode_q;
    end
    if (en_s1_q) begin
      data_d = wave_val;
    end
  end

  // Quarter-wave sine magnitudes, rounded to nearest.
  for (genvar gi = 0; gi < QSIZE; gi++) begin : g_lut
    localparam real ANG = 2.0 * PI * real'(gi) / NPH_R;
    localparam int  VAL = $rtoi(AMP_R * $sin(ANG) + 0.5);
    assign qlut[gi] = MAGW'(VAL);
  end

  // Quadrants 1 and 3 read the table mirrored; the peak (index 0 mirrored) lies past its end.
  assign quad     = phase_q[PHASE_WIDTH-1 -: 2];
  assign q_idx    = phase_q[PHASE_WIDTH-3:0];
  assign q_mirror = -q_idx;
  assign q_sel    = quad[0] ? q_mirror : q_idx;
  assign sine_mag = (quad[0] && (q_idx == '0)) ? AMP : qlut[q_sel];
  assign sine_val = quad[1] ? (MID - {1'b0, sine_mag}) : (MID + {1'b0, sine_mag});

  assign square_val = {DATA_WIDTH{~phase_q[PHASE_WIDTH-1]}};
  assign tri_lvl    = phase_q[PHASE_WIDTH-1] ? ~phase_q[PHASE_WIDTH-2:0] : phase_q[PHASE_WIDTH-2:0];
  assign tri_dbl    = {tri_lvl, 1'b0};
  assign tri_val    = tri_dbl[PHASE_WIDTH-1 -: DATA_WIDTH];
  assign saw_val    = phase_q[PHASE_WIDTH-1 -: DATA_WIDTH];

  always_comb begin
    case (mode_s1_q)
      2'd0:    wave_val = sine_val;
      2'd1:    wave_val = square_val;
      2'd2:    wave_val = tri_val;
      default: wave_val = saw_val;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      ftw_q     <= '0;
      poff_q    <= '0;
      mode_q    <= '0;
      sh_ftw_q  <= '0;
      sh_poff_q <= '0;
      sh_mode_q <= '0;
      acc_q     <= '0;
      wrap_q    <= 1'b0;
      phase_q   <= '0;
      mode_s1_q <= '0;
      en_s1_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ftw_q     <= ftw_d;
      poff_q    <= poff_d;
      mode_q    <= mode_d;
      sh_ftw_q  <= sh_ftw_d;
      sh_poff_q <= sh_poff_d;
      sh_mode_q <= sh_mode_d;
      acc_q     <= acc_d;
      wrap_q    <= wrap_d;
      phase_q   <= phase_d;
      mode_s1_q <= mode_s1_d;
      en_s1_q   <= en_s1_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign cfg_ready_o  = (state_q == ST_IDLE);
  assign cfg_state_o  = state_q[0];
  assign phase_o      = phase_q;
  assign data_out_o   = data_q;
  assign data_valid_o = valid_q;
  assign wrap_o       = wrap_q;

endmodule

// File: tb/tb_dds_core.sv
// Bench for dds_core: directed scenarios plus randomized traffic, compared every cycle
// against an arithmetic model of the accumulator, config handoff and waveform rules.
module tb_dds_core;

  localparam int     AW      = 24;
  localparam int     PW      = 10;
  localparam int     DW      = 10;
  localparam longint ACC_MOD = 64'd1 << AW;
  localparam int     NPH     = 1 << PW;
  localparam real    PI      = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [AW-1:0] cfg_ftw = '0;
  logic [PW-1:0] cfg_poff = '0;
  logic [1:0]    cfg_mode = '0;
  logic [PW-1:0] phase;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          wrap;
  logic          cfg_state;

  always #5 clk = ~clk;

  dds_core dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_ftw_i    (cfg_ftw),
    .cfg_poff_i   (cfg_poff),
    .cfg_mode_i   (cfg_mode),
    .phase_o      (phase),
    .data_out_o   (data_out),
    .data_valid_o (data_valid),
    .wrap_o       (wrap),
    .cfg_state_o  (cfg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string tag, longint got, longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model state
  longint        m_acc, m_ftw, s_ftw;
  int            m_poff, m_mode, s_poff, s_mode;
  bit            m_pending, m_en_prev, m_valid, m_wrap;
  int            m_phase, m_data;
  logic [DW-1:0] exp_q[$];

  function automatic int wave(int mode, int p);
    real r;
    int  ri, t;
    case (mode)
      0: begin
        r  = (2.0 ** (DW - 1) - 1.0) * $sin(2.0 * PI * p / NPH);
        ri = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        return (1 << (DW - 1)) + ri;
      end
      1: return (p < NPH / 2) ? (1 << DW) - 1 : 0;
      2: begin
        t = (p < NPH / 2) ? p : (NPH - 1 - p);
        return (2 * t) >> (PW - DW);
      end
      default: return p >> (PW - DW);
    endcase
  endfunction

  function automatic void model_reset();
    m_acc = 0; m_ftw = 0; s_ftw = 0;
    m_poff = 0; m_mode = 0; s_poff = 0; s_mode = 0;
    m_pending = 0; m_en_prev = 0; m_valid = 0; m_wrap = 0;
    m_phase = 0; m_data = 0;
    exp_q.delete();
  endfunction

  function automatic void model_edge();
    longint sum;
    bit     carry;
    sum   = m_acc + m_ftw;
    carry = enable && (sum >= ACC_MOD);
    m_valid = m_en_prev;
    if (m_en_prev && exp_q.size() > 0) m_data = int'(exp_q.pop_front());
    if (enable) begin
      m_phase = int'(((m_acc >> (AW - PW)) + longint'(m_poff)) % NPH);
      exp_q.push_back(DW'(wave(m_mode, m_phase)));
      m_acc = sum % ACC_MOD;
    end
    m_en_prev = enable;
    m_wrap    = carry;
    if (!m_pending) begin
      if (cfg_valid) begin
        s_ftw = longint'(cfg_ftw); s_poff = int'(cfg_poff); s_mode = int'(cfg_mode);
        m_pending = 1;
      end
    end else if (!enable || carry) begin
      m_ftw = s_ftw; m_poff = s_poff; m_mode = s_mode;
      m_pending = 0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check("phase", phase, m_phase);
    check("data_out", data_out, m_data);
    check("data_valid", data_valid, m_valid);
    check("wrap", wrap, m_wrap);
    check("cfg_ready", cfg_ready, !m_pending);
    check("cfg_state", cfg_state, m_pending);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    cfg_valid = 1'b0;
    #1;
    check("rst_phase", phase, 0);
    check("rst_data", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_wrap", wrap, 0);
    check("rst_ready", cfg_ready, 1);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic offer(longint ftw, int poff, int mode);
    bit done;
    bit rdy;
    done = 0;
    cfg_valid = 1'b1;
    cfg_ftw = AW'(ftw); cfg_poff = PW'(poff); cfg_mode = 2'(mode);
    for (int i = 0; i < 3000 && !done; i++) begin
      rdy = cfg_ready;
      step();
      done = rdy;
    end
    cfg_valid = 1'b0;
    if (!done) check("offer_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wcnt, w1, w2;
    bit found;
    #1;
    do_reset();

    // Sine from zero phase; first samples and wrap period
    offer(24'h004000, 0, 0);
    step();
    check("ready_after_copy", cfg_ready, 1);
    enable = 1'b1;
    step(); step();
    check("sine_first", data_out, 512);
    check("valid_rise", data_valid, 1);
    step(); check("sine_second", data_out, 515);
    step(); check("sine_third", data_out, 518);
    wcnt = 0; w1 = 0; w2 = 0;
    for (int i = 0; i < 2048; i++) begin
      step();
      if (wrap) begin
        wcnt++;
        if (wcnt == 1) w1 = i; else w2 = i;
      end
    end
    check("wrap_count", wcnt, 2);
    check("wrap_period", w2 - w1, 1024);

    // Phase offset of a quarter turn
    do_reset();
    offer(24'h004000, 256, 0);
    step();
    enable = 1'b1;
    step(); step();
    check("poff_first", data_out, 1023);
    found = 0;
    for (int i = 0; i < 1100 && !found; i++) begin
      step();
      found = (phase == 10'd768);
    end
    check("phase768_seen", found, 1);
    step();
    check("sine_768", data_out, 1);

    // Square at half-rate
    do_reset();
    offer(24'h800000, 0, 1);
    step();
    enable = 1'b1;
    step(); check("sq_phase0", phase, 0);
    step(); check("sq_phase1", phase, 512); check("sq_data1", data_out, 1023); check("sq_wrap1", wrap, 1);
    step(); check("sq_phase2", phase, 0);   check("sq_data2", data_out, 0);    check("sq_wrap2", wrap, 0);
    step(); check("sq_phase3", phase, 512); check("sq_data3", data_out, 1023); check("sq_wrap3", wrap, 1);

    // Running retune waits for the wrap edge
    do_reset();
    offer(24'h004000, 0, 3);
    step();
    enable = 1'b1;
    repeat (100) step();
    offer(24'h008000, 0, 3);
    check("retune_pending", cfg_ready, 0);
    found = 0;
    for (int i = 0; i < 1100 && !found; i++) begin
      step();
      found = wrap;
      if (!found) check("retune_ready_low", cfg_ready, 0);
    end
    check("retune_wrap_seen", found, 1);
    check("retune_wrap_phase", phase, 1023);
    check("retune_ready_back", cfg_ready, 1);
    step(); check("retune_phase_a", phase, 0);
    step(); check("retune_phase_b", phase, 2);
    step(); check("retune_phase_c", phase, 4);

    // Reset while a config is pending
    offer(24'h004000, 5, 2);
    check("pending_before_rst", cfg_ready, 0);
    do_reset();
    check("ready_after_rst", cfg_ready, 1);
    enable = 1'b1;
    wcnt = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (wrap) wcnt++;
    end
    check("no_wrap_ftw0", wcnt, 0);

    // Zero ftw keeps a config pending until enable drops
    offer(24'h100000, 0, 2);
    repeat (50) step();
    check("ftw0_still_pending", cfg_ready, 0);
    enable = 1'b0;
    step();
    check("ftw0_applied", cfg_ready, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b1;
        case ($urandom_range(0, 3))
          0:       cfg_ftw = '0;
          1:       cfg_ftw = AW'($urandom_range(1, 4095));
          default: cfg_ftw = AW'($urandom_range(0, (1 << AW) - 1));
        endcase
        cfg_poff = PW'($urandom_range(0, NPH - 1));
        cfg_mode = 2'($urandom_range(0, 3));
      end else begin
        cfg_valid = 1'b0;
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
